// File: rtl/rs_pkg.sv
// Code geometry, generator coefficients and GF(2^8) multiply for the RS(198,194) encoder.
package rs_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam int         RS_N     = 198;
  localparam int         RS_K     = 194;
  localparam int         RS_NSYM  = RS_N - RS_K;
  localparam int         RS_BEATS = 24;

  // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots a^0..a^3
  localparam logic [7:0] G3 = 8'h0F;
  localparam logic [7:0] G2 = 8'h36;
  localparam logic [7:0] G1 = 8'h78;
  localparam logic [7:0] G0 = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  // Shift-and-add multiply reduced by the field polynomial
  function automatic logic [7:0] gf2m8_multi(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_enc_p8_if.sv
// Encoder handshake bundle: frame start/sync, payload in, payload/parity out.
interface rs_enc_p8_if;

  logic        enc_start;
  logic [11:0] enc_sync;
  logic        enc_data_vld;
  logic [63:0] enc_data;
  logic        enc_ready;
  logic        enc_busy;
  logic        enc_dout_vld;
  logic [63:0] enc_dout;
  logic        enc_parity_vld;
  logic [31:0] enc_parity;
  logic        enc_start_drop;

  modport master (
    output enc_start, enc_sync, enc_data_vld, enc_data,
    input  enc_ready, enc_busy, enc_dout_vld, enc_dout,
    input  enc_parity_vld, enc_parity, enc_start_drop
  );

  modport slave (
    input  enc_start, enc_sync, enc_data_vld, enc_data,
    output enc_ready, enc_busy, enc_dout_vld, enc_dout,
    output enc_parity_vld, enc_parity, enc_start_drop
  );

endinterface

// File: rtl/rs_enc_step8.sv
// Combinational parity LFSR advance by 8 symbols (or 2 for the sync header).
// sym_in[63:56] is the earliest (highest-degree) symbol.
module rs_enc_step8
  import rs_pkg::*;
(
  input  logic [RS_NSYM-1:0][7:0] r_in,
  input  logic [63:0]             sym_in,
  input  logic                    sync_sel,
  output logic [RS_NSYM-1:0][7:0] r_out
);

  // One division step: shift in symbol s, subtract fb*g(x)
  function automatic logic [RS_NSYM-1:0][7:0] lfsr_step(input logic [RS_NSYM-1:0][7:0] r,
                                                        input logic [7:0] s);
    logic [7:0]               fb;
    logic [RS_NSYM-1:0][7:0]  nx;
    fb    = s ^ r[3];
    nx[3] = r[2] ^ gf2m8_multi(fb, G3);
    nx[2] = r[1] ^ gf2m8_multi(fb, G2);
    nx[1] = r[0] ^ gf2m8_multi(fb, G1);
    nx[0] = gf2m8_multi(fb, G0);
    return nx;
  endfunction

  logic [RS_NSYM-1:0][7:0] stage [9];

  // Cascade of eight single-symbol steps; sync uses the first two taps
  always_comb begin
    stage[0] = r_in;
    for (int i = 0; i < 8; i++) begin
      stage[i+1] = lfsr_step(stage[i], sym_in[63-8*i -: 8]);
    end
    r_out = sync_sel ? stage[2] : stage[8];
  end

endmodule

// File: rtl/rs_enc_p8.sv
// Systematic RS(198,194) encoder, 8 symbols/clock: payload passthrough
// with one-cycle latency and a 4-symbol parity strobe after beat 23.
//
// state   | meaning
// IDLE    | waiting for enc_start, LFSR holds zero
// DATA    | absorbing payload beats, stalls on enc_data_vld=0
// DONE    | parity strobe out, LFSR cleared
module rs_enc_p8
  import rs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  rs_enc_p8_if.slave  bus
);

  enc_state_t              state, state_nxt;
  logic [4:0]              beat_cnt, beat_cnt_nxt;
  logic [RS_NSYM-1:0][7:0] lfsr, lfsr_nxt;
  logic [RS_NSYM-1:0][7:0] step_r;
  logic [RS_NSYM-1:0][7:0] step_in;
  logic [63:0]             step_sym;
  logic                    step_sync;
  logic                    par_load;
  logic                    dout_vld_q;
  logic [63:0]             dout_q;
  logic [31:0]             parity_q;
  logic                    start_drop_q;

  // In IDLE the step absorbs the two sync symbols from a zero state
  assign step_sync = (state == ST_IDLE);
  assign step_in   = step_sync ? '0 : lfsr;
  assign step_sym  = step_sync ? {4'b0000, bus.enc_sync, 48'h0} : bus.enc_data;

  rs_enc_step8 u_step (
    .r_in     (step_in),
    .sym_in   (step_sym),
    .sync_sel (step_sync),
    .r_out    (step_r)
  );

  // Next-state, counter and LFSR update
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    lfsr_nxt     = lfsr;
    par_load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enc_start) begin
          lfsr_nxt     = step_r;
          beat_cnt_nxt = 5'd0;
          state_nxt    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.enc_data_vld) begin
          lfsr_nxt     = step_r;
          beat_cnt_nxt = beat_cnt + 5'd1;
          if (beat_cnt == 5'(RS_BEATS - 1)) begin
            par_load  = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        lfsr_nxt  = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        lfsr_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, LFSR and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      beat_cnt     <= 5'd0;
      lfsr         <= '0;
      dout_vld_q   <= 1'b0;
      dout_q       <= 64'h0;
      parity_q     <= 32'h0;
      start_drop_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      lfsr         <= lfsr_nxt;
      dout_vld_q   <= (state == ST_DATA) && bus.enc_data_vld;
      if ((state == ST_DATA) && bus.enc_data_vld) dout_q <= bus.enc_data;
      if (par_load) parity_q <= step_r;
      start_drop_q <= bus.enc_start && (state != ST_IDLE);
    end
  end

  assign bus.enc_ready      = (state == ST_IDLE);
  assign bus.enc_busy       = (state != ST_IDLE);
  assign bus.enc_parity_vld = (state == ST_DONE);
  assign bus.enc_dout_vld   = dout_vld_q;
  assign bus.enc_dout       = dout_q;
  assign bus.enc_parity     = parity_q;
  assign bus.enc_start_drop = start_drop_q;

endmodule

// File: tb/tb_rs_enc_p8.sv
// Self-checking bench for rs_enc_p8: fixed vectors, random frames against a
// long-division reference, stalls, dropped starts and mid-frame reset.
module tb_rs_enc_p8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rs_enc_p8_if bus ();

  rs_enc_p8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] pay [24];
  logic [31:0] got_par;

  typedef struct {
    logic [11:0] sync;
    int          beat;
    int          byte_i;
    logic [7:0]  val;
    logic [31:0] exp_par;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Carry-less product then polynomial reduction by 0x11D from the top bit down
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11D << (k - 8));
    return p[7:0];
  endfunction

  // Message symbol i (0 = x^197 ... 193 = x^4)
  function automatic logic [7:0] msg_sym(input logic [11:0] sync, input int i);
    int idx;
    if (i == 0) return {4'b0000, sync[11:8]};
    if (i == 1) return sync[7:0];
    idx = i - 2;
    return pay[idx / 8][63 - 8 * (idx % 8) -: 8];
  endfunction

  // Remainder of m(x)*x^4 by g(x) via schoolbook long division
  function automatic logic [31:0] ref_parity(input logic [11:0] sync);
    logic [7:0] cw [198];
    logic [7:0] g  [5];
    logic [7:0] coef;
    g = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};
    for (int i = 0; i < 194; i++) cw[i] = msg_sym(sync, i);
    for (int i = 194; i < 198; i++) cw[i] = 8'h00;
    for (int i = 0; i < 194; i++) begin
      coef = cw[i];
      for (int j = 1; j < 5; j++) cw[i+j] = cw[i+j] ^ gmul(coef, g[j]);
    end
    return {cw[194], cw[195], cw[196], cw[197]};
  endfunction

  // Codeword evaluated at x (Horner), parity from the DUT
  function automatic logic [7:0] eval_cw(input logic [11:0] sync, input logic [31:0] par,
                                         input logic [7:0] x);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 194; i++) acc = gmul(acc, x) ^ msg_sym(sync, i);
    for (int k = 3; k >= 0; k--) acc = gmul(acc, x) ^ par[8*k +: 8];
    return acc;
  endfunction

  task automatic idle_inputs();
    bus.enc_start    = 1'b0;
    bus.enc_data_vld = 1'b0;
  endtask

  // One frame from the current pay[] contents
  task automatic run_frame(input logic [11:0] sync, input bit gaps, input int drop_at,
                           input logic [31:0] exp_par, input string tag);
    @(negedge clk);
    bus.enc_start = 1'b1;
    bus.enc_sync  = sync;
    @(posedge clk); #1;
    chk({tag, "_busy_after_start"}, bus.enc_busy, 1);
    chk({tag, "_ready_after_start"}, bus.enc_ready, 0);
    for (int b = 0; b < 24; b++) begin
      if (gaps) begin
        @(negedge clk);
        bus.enc_start    = 1'b0;
        bus.enc_data_vld = 1'b0;
        bus.enc_data     = {$urandom, $urandom};
        @(posedge clk); #1;
        chk({tag, "_gap_no_dout"}, bus.enc_dout_vld, 0);
        chk({tag, "_gap_busy"}, bus.enc_busy, 1);
      end
      @(negedge clk);
      bus.enc_start    = (b == drop_at);
      bus.enc_data_vld = 1'b1;
      bus.enc_data     = pay[b];
      @(posedge clk); #1;
      chk({tag, "_dout_vld"}, bus.enc_dout_vld, 1);
      chk({tag, "_dout"}, bus.enc_dout, pay[b]);
      chk({tag, "_parity_vld"}, bus.enc_parity_vld, (b == 23) ? 1 : 0);
      if (b == drop_at) chk({tag, "_start_drop_pulse"}, bus.enc_start_drop, 1);
      if (drop_at >= 0 && b == drop_at + 1) chk({tag, "_start_drop_clear"}, bus.enc_start_drop, 0);
      if (b == 23) begin
        got_par = bus.enc_parity;
        chk({tag, "_parity"}, bus.enc_parity, exp_par);
      end
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    chk({tag, "_strobe_one_cycle"}, bus.enc_parity_vld, 0);
    chk({tag, "_ready_after_done"}, bus.enc_ready, 1);
    chk({tag, "_no_dout_after"}, bus.enc_dout_vld, 0);
    chk({tag, "_parity_hold"}, bus.enc_parity, exp_par);
  endtask

  logic [11:0] rsync;
  logic [31:0] rpar;
  int          strobes;

  initial begin
    rst              = 1'b1;
    bus.enc_start    = 1'b0;
    bus.enc_sync     = 12'h0;
    bus.enc_data_vld = 1'b0;
    bus.enc_data     = 64'h0;
    got_par          = 32'h0;

    vecs[0] = '{12'h000, 0,  0, 8'h00, 32'h00000000};
    vecs[1] = '{12'h000, 23, 0, 8'h01, 32'h0F367840};
    vecs[2] = '{12'h000, 23, 0, 8'h02, 32'h1E6CF080};
    vecs[3] = '{12'h000, 23, 1, 8'h01, 32'h6357D2E7};
    vecs[4] = '{12'h000, 22, 7, 8'h00, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.enc_ready, 1);
    chk("rst_busy", bus.enc_busy, 0);
    chk("rst_dout_vld", bus.enc_dout_vld, 0);
    chk("rst_dout", bus.enc_dout, 0);
    chk("rst_parity_vld", bus.enc_parity_vld, 0);
    chk("rst_parity", bus.enc_parity, 0);
    chk("rst_start_drop", bus.enc_start_drop, 0);

    // reset and start together: reset wins
    @(negedge clk);
    bus.enc_start = 1'b1;
    bus.enc_sync  = 12'hABC;
    @(posedge clk); #1;
    chk("rst_start_ready", bus.enc_ready, 1);
    chk("rst_start_busy", bus.enc_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // valid beat while idle is ignored
    @(negedge clk);
    bus.enc_data_vld = 1'b1;
    bus.enc_data     = 64'hDEADBEEF_01234567;
    @(posedge clk); #1;
    chk("idle_vld_no_dout", bus.enc_dout_vld, 0);
    chk("idle_vld_still_idle", bus.enc_ready, 1);
    @(negedge clk);
    idle_inputs();

    // fixed vectors
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < 24; b++) pay[b] = 64'h0;
      pay[vecs[v].beat][8*vecs[v].byte_i +: 8] = vecs[v].val;
      run_frame(vecs[v].sync, 1'b0, -1, vecs[v].exp_par, $sformatf("vec%0d", v));
    end

    // random frames: model parity, codeword roots at a^0..a^3
    for (int f = 0; f < 20; f++) begin
      rsync = 12'($urandom);
      for (int b = 0; b < 24; b++) pay[b] = {$urandom, $urandom};
      rpar = ref_parity(rsync);
      run_frame(rsync, (f % 4) == 1, (f == 2) ? 10 : -1, rpar, $sformatf("rnd%0d", f));
      chk($sformatf("rnd%0d_syn0", f), eval_cw(rsync, got_par, 8'h01), 0);
      chk($sformatf("rnd%0d_syn1", f), eval_cw(rsync, got_par, 8'h02), 0);
      chk($sformatf("rnd%0d_syn2", f), eval_cw(rsync, got_par, 8'h04), 0);
      chk($sformatf("rnd%0d_syn3", f), eval_cw(rsync, got_par, 8'h08), 0);
    end

    // same payload, back-to-back then stalled every other cycle
    rsync = 12'h5A3;
    for (int b = 0; b < 24; b++) pay[b] = {$urandom, $urandom};
    rpar = ref_parity(rsync);
    run_frame(rsync, 1'b0, -1, rpar, "b2b");
    run_frame(rsync, 1'b1, -1, rpar, "stall");

    // reset at beat 12 aborts the frame
    rsync = 12'($urandom);
    for (int b = 0; b < 24; b++) pay[b] = {$urandom, $urandom};
    @(negedge clk);
    bus.enc_start = 1'b1;
    bus.enc_sync  = rsync;
    for (int b = 0; b < 12; b++) begin
      @(negedge clk);
      bus.enc_start    = 1'b0;
      bus.enc_data_vld = 1'b1;
      bus.enc_data     = pay[b];
    end
    @(negedge clk);
    rst              = 1'b1;
    bus.enc_data     = pay[12];
    @(posedge clk); #1;
    chk("abort_no_dout", bus.enc_dout_vld, 0);
    chk("abort_no_strobe", bus.enc_parity_vld, 0);
    chk("abort_ready", bus.enc_ready, 1);
    chk("abort_busy", bus.enc_busy, 0);
    @(negedge clk);
    rst              = 1'b0;
    bus.enc_data_vld = 1'b1;
    strobes          = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.enc_parity_vld || bus.enc_dout_vld) strobes++;
    end
    chk("abort_quiet_after", 64'(strobes), 0);
    @(negedge clk);
    idle_inputs();
    rsync = 12'($urandom);
    for (int b = 0; b < 24; b++) pay[b] = {$urandom, $urandom};
    rpar = ref_parity(rsync);
    run_frame(rsync, 1'b0, -1, rpar, "post_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
